instr_encoder_loader: RTL and testbench

Program-load block that builds 32-bit instruction words from operation fields and writes them sequentially into instruction memory. It uses the same RV32I subset and encodings the core decoder accepts: ADD, SUB, LW, SW, ADDI, LUI and JAL. It sits between a test/boot sequencer and the instruction-memory write port. It is used to preload programs before the core is released from reset.

---
 rtl/instr_encoder_loader.sv | 179 +++++++++++++++++
 tb/tb_instr_encoder_loader.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
// Builds RV32I instruction words (ADD, SUB, LW, SW, ADDI, LUI, JAL, NOP)
// from operation fields and writes them to consecutive instruction-memory
// words, so a program can be preloaded before the core leaves reset.
//
// Optional feature macro: ENC_RANGE_CHECK_EN
//   When defined, each accepted immediate is range-checked. An out-of-range
//   immediate is written as NOP and sets the sticky err flag. When the macro
//   is undefined, err is tied low and out-of-range bits are simply dropped.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           begin a load session (IDLE only)
//   base_addr       first byte address (low two bits ignored)
//   in_valid/ready  field bundle handshake (ready only while RUN)
//   in_op/rd/rs1/rs2/imm/last  instruction fields, last marks final word
//   mem_we/addr/wdata  instruction-memory write port, one cycle after accept
//   busy            session in progress (RUN or DONE)
//   done            one-cycle pulse coincident with the final write
//   word_count      words written in the current/last session
//   err             sticky immediate-range error
module instr_encoder_loader #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] word_count,
  output logic              err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
  typedef enum logic [2:0] {
    OP_ADD = 3'd0, OP_SUB = 3'd1, OP_LW  = 3'd2, OP_SW  = 3'd3,
    OP_ADDI = 3'd4, OP_LUI = 3'd5, OP_JAL = 3'd6, OP_NOP = 3'd7
  } op_e;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              accept;
  logic              imm_bad;
  logic [31:0]       raw_word;
  logic [31:0]       enc_word;
  op_e               op;

  assign op     = op_e'(in_op);
  assign accept = in_valid && in_ready;

  // Encoder
  always_comb begin
    raw_word = NOP_WORD;
    unique case (op)
      OP_ADD:  raw_word = {7'b0000000, in_rs2, in_rs1, 3'b000, in_rd, 7'b0110011};
      OP_SUB:  raw_word = {7'b0100000, in_rs2, in_rs1, 3'b000, in_rd, 7'b0110011};
      OP_LW:   raw_word = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
      OP_SW:   raw_word = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
      OP_ADDI: raw_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b0010011};
      OP_LUI:  raw_word = {in_imm[31:12], in_rd, 7'b0110111};
      OP_JAL:  raw_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                           in_rd, 7'b1101111};
      OP_NOP:  raw_word = NOP_WORD;
      default: raw_word = NOP_WORD;
    endcase
  end

  always_comb begin
    imm_bad = 1'b0;
`ifdef ENC_RANGE_CHECK_EN
    unique case (op)
      OP_LW, OP_SW, OP_ADDI: imm_bad = !((&in_imm[31:11]) || !(|in_imm[31:11]));
      OP_LUI:                imm_bad = |in_imm[11:0];
      OP_JAL:                imm_bad = in_imm[0] || !((&in_imm[31:20]) || !(|in_imm[31:20]));
      default:               imm_bad = 1'b0;
    endcase
`endif
    enc_word = imm_bad ? NOP_WORD : raw_word;
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = base_addr & ~ADDR_W'(3);
          count_d = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (accept) begin
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = enc_word;
          addr_d  = addr_q + ADDR_W'(4);
          count_d = count_q + ADDR_W'(1);
          // The final write lands in DONE, so done and mem_we coincide.
          if (in_last || (count_d == ADDR_W'(MAX_WORDS)))
            state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready = (state_q == S_RUN);
    busy     = (state_q == S_RUN) || (state_q == S_DONE);
    done     = (state_q == S_DONE);
  end

  assign mem_we     = we_q;
  assign mem_addr   = waddr_q;
  assign mem_wdata  = wdata_q;
  assign word_count = count_q;

`ifdef ENC_RANGE_CHECK_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (rst)
      err_q <= 1'b0;
    else if ((state_q == S_IDLE) && start)
      err_q <= 1'b0;
    else if (accept && imm_bad)
      err_q <= 1'b1;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  base_addr;
  logic        in_valid;
  logic [2:0]  in_op;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        in_last;

  logic        in_ready, mem_we, busy, done, err;
  logic [7:0]  mem_addr, word_count;
  logic [31:0] mem_wdata;

  logic        ready4, we4, busy4, done4, err4;
  logic [7:0]  addr4, cnt4;
  logic [31:0] wdata4;

  int cmp = 0;
  int fails = 0;

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_W(8), .MAX_WORDS(64)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .word_count(word_count), .err(err)
  );

  instr_encoder_loader #(.ADDR_W(8), .MAX_WORDS(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(ready4), .in_op(in_op), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
    .mem_we(we4), .mem_addr(addr4), .mem_wdata(wdata4),
    .busy(busy4), .done(done4), .word_count(cnt4), .err(err4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm, input logic last);
    in_valid = 1'b1;
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0;
    in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_last = 1'b0;
    tick(); tick();
    cmp++;
    if ({in_ready, mem_we, done, busy, err} !== 5'b0) begin
      fails++;
      $display("FAIL reset_flags got %b exp 00000", {in_ready, mem_we, done, busy, err});
    end
    cmp++;
    if ({mem_addr, word_count, mem_wdata} !== 48'h0) begin
      fails++;
      $display("FAIL reset_data got addr=%h cnt=%h wdata=%h exp 0", mem_addr, word_count, mem_wdata);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_session();
    logic [2:0]  ops  [4] = '{3'd0, 3'd1, 3'd3, 3'd2};
    logic [4:0]  rds  [4] = '{5'd3, 5'd5, 5'd0, 5'd3};
    logic [4:0]  rs1s [4] = '{5'd1, 5'd6, 5'd1, 5'd1};
    logic [4:0]  rs2s [4] = '{5'd2, 5'd7, 5'd2, 5'd0};
    logic [31:0] imms [4] = '{32'd0, 32'd0, 32'd8, 32'd4};
    logic [31:0] expw [4] = '{32'h002081B3, 32'h407302B3, 32'h0020A423, 32'h0040A183};
    start = 1'b1; base_addr = 8'h43;
    tick();
    start = 1'b0;
    cmp++;
    if ({busy, in_ready, mem_we} !== 3'b110 || word_count !== 8'd0) begin
      fails++;
      $display("FAIL basic_run_entry got busy/ready/we=%b cnt=%0d exp 110 cnt=0",
               {busy, in_ready, mem_we}, word_count);
    end
    for (int i = 0; i < 4; i++) begin
      drive(ops[i], rds[i], rs1s[i], rs2s[i], imms[i], i == 3);
      tick();
      cmp++;
      if (mem_we !== 1'b1 || mem_addr !== 8'(8'h40 + 4 * i) || mem_wdata !== expw[i]) begin
        fails++;
        $display("FAIL basic_write%0d got we=%b addr=%h data=%h exp we=1 addr=%h data=%h",
                 i, mem_we, mem_addr, mem_wdata, 8'(8'h40 + 4 * i), expw[i]);
      end
      cmp++;
      if (word_count !== 8'(i + 1) || done !== (i == 3) || in_ready !== (i != 3)) begin
        fails++;
        $display("FAIL basic_status%0d got cnt=%0d done=%b ready=%b exp cnt=%0d done=%b ready=%b",
                 i, word_count, done, in_ready, i + 1, i == 3, i != 3);
      end
    end
    in_valid = 1'b0;
    tick();
    cmp++;
    if ({mem_we, busy, done, in_ready} !== 4'b0 || word_count !== 8'd4) begin
      fails++;
      $display("FAIL basic_idle got we/busy/done/ready=%b cnt=%0d exp 0000 cnt=4",
               {mem_we, busy, done, in_ready}, word_count);
    end
  endtask

  task automatic test_encodings();
    logic [2:0]  ops  [4] = '{3'd5, 3'd6, 3'd4, 3'd7};
    logic [4:0]  rds  [4] = '{5'd1, 5'd1, 5'd1, 5'd9};
    logic [4:0]  rs1s [4] = '{5'd0, 5'd0, 5'd0, 5'd4};
    logic [31:0] imms [4] = '{32'h12345000, 32'd8, 32'hFFFFFFFF, 32'h55};
    logic [31:0] expw [4] = '{32'h123450B7, 32'h008000EF, 32'hFFF00093, 32'h00000013};
    start = 1'b1; base_addr = 8'h00;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(ops[i], rds[i], rs1s[i], 5'd3, imms[i], i == 3);
      tick();
      cmp++;
      if (mem_we !== 1'b1 || mem_addr !== 8'(4 * i) || mem_wdata !== expw[i]) begin
        fails++;
        $display("FAIL enc_write%0d got we=%b addr=%h data=%h exp we=1 addr=%h data=%h",
                 i, mem_we, mem_addr, mem_wdata, 8'(4 * i), expw[i]);
      end
    end
    cmp++;
    if (err !== 1'b0 || done !== 1'b1) begin
      fails++;
      $display("FAIL enc_end got err=%b done=%b exp err=0 done=1", err, done);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_max_words_wrap();
    logic [7:0]  ea;
    logic [31:0] ew;
    rst = 1'b1; tick(); rst = 1'b0;
    start = 1'b1; base_addr = 8'hF8;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(3'd4, 5'(i + 1), 5'd0, 5'd0, 32'(i), 1'b0);
      tick();
      ea = 8'hF8 + 8'(4 * i);
      ew = 32'h13 | (32'(i) << 20) | (32'(i + 1) << 7);
      if (i < 4) begin
        cmp++;
        if (we4 !== 1'b1 || addr4 !== ea || wdata4 !== ew || err4 !== 1'b0) begin
          fails++;
          $display("FAIL max_write%0d got we=%b addr=%h data=%h err=%b exp we=1 addr=%h data=%h err=0",
                   i, we4, addr4, wdata4, err4, ea, ew);
        end
        cmp++;
        if (cnt4 !== 8'(i + 1) || done4 !== (i == 3) || ready4 !== (i != 3)) begin
          fails++;
          $display("FAIL max_status%0d got cnt=%0d done=%b ready=%b exp cnt=%0d done=%b ready=%b",
                   i, cnt4, done4, ready4, i + 1, i == 3, i != 3);
        end
      end else begin
        cmp++;
        if ({we4, busy4, done4, ready4} !== 4'b0 || cnt4 !== 8'd4) begin
          fails++;
          $display("FAIL max_fifth_rejected got we/busy/done/ready=%b cnt=%0d exp 0000 cnt=4",
                   {we4, busy4, done4, ready4}, cnt4);
        end
      end
      // The 64-word instance keeps accepting: only in_last or its own limit ends it.
      cmp++;
      if (mem_we !== 1'b1 || mem_addr !== ea || word_count !== 8'(i + 1) || done !== 1'b0) begin
        fails++;
        $display("FAIL max64_write%0d got we=%b addr=%h cnt=%0d done=%b exp we=1 addr=%h cnt=%0d done=0",
                 i, mem_we, mem_addr, word_count, done, ea, i + 1);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_rst_abort();
    rst = 1'b1; tick(); rst = 1'b0;
    start = 1'b1; base_addr = 8'h20;
    tick();
    drive(3'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
    tick();
    cmp++;
    if (mem_we !== 1'b1 || mem_addr !== 8'h20 || word_count !== 8'd1) begin
      fails++;
      $display("FAIL abort_w0 got we=%b addr=%h cnt=%0d exp we=1 addr=20 cnt=1", mem_we, mem_addr, word_count);
    end
    drive(3'd1, 5'd5, 5'd6, 5'd7, 32'd0, 1'b0);
    tick();
    cmp++;
    if (mem_we !== 1'b1 || mem_addr !== 8'h24 || word_count !== 8'd2 || mem_wdata !== 32'h407302B3) begin
      fails++;
      $display("FAIL abort_start_ignored got we=%b addr=%h cnt=%0d data=%h exp we=1 addr=24 cnt=2 data=407302b3",
               mem_we, mem_addr, word_count, mem_wdata);
    end
    rst = 1'b1;
    tick();
    cmp++;
    if ({mem_we, busy, done, in_ready, err} !== 5'b0 || word_count !== 8'd0 ||
        mem_addr !== 8'd0 || mem_wdata !== 32'd0) begin
      fails++;
      $display("FAIL abort_reset got flags=%b cnt=%0d addr=%h data=%h exp 00000 cnt=0 addr=0 data=0",
               {mem_we, busy, done, in_ready, err}, word_count, mem_addr, mem_wdata);
    end
    rst = 1'b0; start = 1'b0;
    tick();
    cmp++;
    if ({mem_we, busy, in_ready} !== 3'b0) begin
      fails++;
      $display("FAIL abort_after got we/busy/ready=%b exp 000", {mem_we, busy, in_ready});
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_range_check();
    logic [31:0] exp_w;
    logic        exp_e;
`ifdef ENC_RANGE_CHECK_EN
    exp_w = 32'h00000013; exp_e = 1'b1;
`else
    exp_w = 32'h80000013; exp_e = 1'b0;
`endif
    start = 1'b1; base_addr = 8'h10;
    tick();
    start = 1'b0;
    drive(3'd4, 5'd0, 5'd0, 5'd0, 32'h800, 1'b1);
    tick();
    cmp++;
    if (mem_we !== 1'b1 || mem_wdata !== exp_w || err !== exp_e || done !== 1'b1) begin
      fails++;
      $display("FAIL range_write got we=%b data=%h err=%b done=%b exp we=1 data=%h err=%b done=1",
               mem_we, mem_wdata, err, done, exp_w, exp_e);
    end
    in_valid = 1'b0;
    tick(); tick();
    cmp++;
    if (err !== exp_e || busy !== 1'b0) begin
      fails++;
      $display("FAIL range_sticky got err=%b busy=%b exp err=%b busy=0", err, busy, exp_e);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    cmp++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL range_clear got err=%b busy=%b exp err=0 busy=1", err, busy);
    end
    drive(3'd4, 5'd0, 5'd0, 5'd0, 32'd5, 1'b1);
    tick();
    cmp++;
    if (mem_wdata !== 32'h00500013 || err !== 1'b0 || mem_addr !== 8'h10) begin
      fails++;
      $display("FAIL range_legal got data=%h err=%b addr=%h exp data=00500013 err=0 addr=10",
               mem_wdata, err, mem_addr);
    end
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_session();
    test_encodings();
    test_max_words_wrap();
    test_rst_abort();
    test_range_check();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
    $finish;
  end

endmodule
